// File: rtl/pulse_meter_pkg.sv
// Shared types and helpers for pulse_meter: FSM states, saturation limits, saturating increment.
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } pm_state_e;

  localparam int CNT_W_DEF = 8;
  localparam int TOT_W_DEF = 16;

  function automatic int unsigned cnt_max(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned SAT_MAX_DEF = cnt_max(CNT_W_DEF);

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max);
    return (value >= max) ? max : value + 32'd1;
  endfunction

endpackage

// File: rtl/pm_sat_counter.sv
// Saturating up-counter used for the width and gap measurements of pulse_meter.
module pm_sat_counter
  import pulse_meter_pkg::*;
#(
  parameter int          W   = CNT_W_DEF,
  parameter int unsigned MAX = SAT_MAX_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         at_max
);

  logic [W-1:0] r_q;

  // load1 wins over clr so a counter can restart on the same cycle it is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (load1) begin
      r_q <= W'(1);
    end else if (clr) begin
      r_q <= '0;
    end else if (inc) begin
      r_q <= W'(sat_inc(32'(r_q), MAX));
    end
  end

  assign q      = r_q;
  assign at_max = (32'(r_q) == MAX);

endmodule

// File: rtl/pulse_meter.sv
// Measures high pulses and the preceding low gap on a serial stream, one record per pulse.
// Optional macro PULSE_METER_GLITCH_FILTER_EN folds width-1 pulses into the ongoing gap.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TOT_W = TOT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] m_width,
  output logic [CNT_W-1:0] m_gap,
  output logic             m_sat,
  output logic [TOT_W-1:0] pulse_cnt,
  output logic             dropped,
  output logic [1:0]       dbg_state
);

  // Handshake: a record transfers on a posedge with m_valid && m_ready; while m_valid is
  // high and m_ready low the record holds steady, and m_valid never drops without a transfer.

  pm_state_e        r_state, w_state_nxt;
  logic             r_din_q;
  logic             w_rise, w_fall;
  logic             w_w_load1, w_w_inc, w_w_clr;
  logic             w_g_load1, w_g_inc;
  logic             w_complete;
  logic [CNT_W-1:0] w_width, w_gap, w_rec_gap;
  logic             w_width_max, w_gap_max, w_rec_gap_max;

  logic             r_valid, r_sat, r_dropped;
  logic [CNT_W-1:0] r_width, r_gap;
  logic [TOT_W-1:0] r_cnt;

  assign w_rise = din & ~r_din_q;
  assign w_fall = ~din & r_din_q;

`ifdef PULSE_METER_GLITCH_FILTER_EN
  // The gap counter keeps running through a candidate glitch, so the real pulse's gap is
  // snapshotted at the rising edge.
  logic [CNT_W-1:0] r_gap_pre;
  logic             r_gap_pre_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gap_pre     <= '0;
      r_gap_pre_max <= 1'b0;
    end else if (r_state == LOW && w_rise) begin
      r_gap_pre     <= w_gap;
      r_gap_pre_max <= w_gap_max;
    end
  end

  assign w_rec_gap     = r_gap_pre;
  assign w_rec_gap_max = r_gap_pre_max;
`else
  assign w_rec_gap     = w_gap;
  assign w_rec_gap_max = w_gap_max;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_w_load1   = 1'b0;
    w_w_inc     = 1'b0;
    w_w_clr     = 1'b0;
    w_g_load1   = 1'b0;
    w_g_inc     = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      SYNC: begin
        if (din == 1'b0) begin
          w_g_load1   = 1'b1;
          w_state_nxt = LOW;
        end
      end
      LOW: begin
        if (w_rise) begin
          w_w_load1   = 1'b1;
          w_state_nxt = HIGH;
`ifdef PULSE_METER_GLITCH_FILTER_EN
          w_g_inc     = 1'b1;
`endif
        end else begin
          w_g_inc = 1'b1;
        end
      end
      HIGH: begin
        if (w_fall) begin
          w_w_clr     = 1'b1;
          w_state_nxt = LOW;
`ifdef PULSE_METER_GLITCH_FILTER_EN
          if (w_width == CNT_W'(1)) begin
            w_g_inc = 1'b1;
          end else begin
            w_complete = 1'b1;
            w_g_load1  = 1'b1;
          end
`else
          w_complete = 1'b1;
          w_g_load1  = 1'b1;
`endif
        end else begin
          w_w_inc = 1'b1;
        end
      end
      default: w_state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SYNC;
      r_din_q <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_din_q <= din;
    end
  end

  pm_sat_counter #(.W(CNT_W), .MAX(cnt_max(CNT_W))) u_width (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_w_clr),
    .load1  (w_w_load1),
    .inc    (w_w_inc),
    .q      (w_width),
    .at_max (w_width_max)
  );

  pm_sat_counter #(.W(CNT_W), .MAX(cnt_max(CNT_W))) u_gap (
    .clk    (clk),
    .rst    (rst),
    .clr    (1'b0),
    .load1  (w_g_load1),
    .inc    (w_g_inc),
    .q      (w_gap),
    .at_max (w_gap_max)
  );

  // A completion into a busy slot is counted but discarded; accept-and-capture replaces.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_width   <= '0;
      r_gap     <= '0;
      r_sat     <= 1'b0;
      r_cnt     <= '0;
      r_dropped <= 1'b0;
    end else if (w_complete) begin
      r_cnt <= r_cnt + TOT_W'(1);
      if (!r_valid || m_ready) begin
        r_valid <= 1'b1;
        r_width <= w_width;
        r_gap   <= w_rec_gap;
        r_sat   <= w_width_max | w_rec_gap_max;
      end else begin
        r_dropped <= 1'b1;
      end
    end else if (r_valid && m_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign m_valid   = r_valid;
  assign m_width   = r_width;
  assign m_gap     = r_gap;
  assign m_sat     = r_sat;
  assign pulse_cnt = r_cnt;
  assign dropped   = r_dropped;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: directed scenarios plus random streams, checked against a
// history-based reference that derives each record from the run lengths of din.
module tb_pulse_meter;

  localparam int CNT_W = 8;
  localparam int TOT_W = 16;
  localparam int SMAX  = 255;

  logic             clk;
  logic             rst;
  logic             din;
  logic             m_valid;
  logic             m_ready;
  logic [CNT_W-1:0] m_width;
  logic [CNT_W-1:0] m_gap;
  logic             m_sat;
  logic [TOT_W-1:0] pulse_cnt;
  logic             dropped;
  logic [1:0]       dbg_state;

  pulse_meter #(.CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_width   (m_width),
    .m_gap     (m_gap),
    .m_sat     (m_sat),
    .pulse_cnt (pulse_cnt),
    .dropped   (dropped),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  int          vectors = 0;
  int          miscompares = 0;
  bit          hist[$];
  logic [16:0] exp_q[$];
  logic [16:0] last_rec = '0;
  int          exp_cnt = 0;
  bit          exp_drop = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: on a 1->0 sample, width is the run of ones just ended and gap is the run
  // of zeros before it; a ones-run with no zero before it is a startup high.
  task automatic model_update(input bit d, input bit r);
    int n, i, width, gap;
    logic [16:0] rec;
    if (r) begin
      hist.delete();
      exp_q.delete();
      last_rec = '0;
      exp_cnt  = 0;
      exp_drop = 1'b0;
      return;
    end
    hist.push_back(d);
    n = hist.size();
    if (d == 1'b0 && n >= 2 && hist[n-2] == 1'b1) begin
      width = 0;
      i = n - 2;
      while (i >= 0 && hist[i] == 1'b1) begin width++; i--; end
      if (i >= 0) begin
        gap = 0;
        while (i >= 0 && hist[i] == 1'b0) begin gap++; i--; end
        rec[7:0]  = 8'((width > SMAX) ? SMAX : width);
        rec[15:8] = 8'((gap > SMAX) ? SMAX : gap);
        rec[16]   = (width >= SMAX) || (gap >= SMAX);
        exp_cnt   = (exp_cnt + 1) % 65536;
        if (exp_q.size() == 0) begin
          exp_q.push_back(rec);
          last_rec = rec;
        end else begin
          exp_drop = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [1:0] exp_state();
    bit synced = 1'b0;
    foreach (hist[k]) if (hist[k] == 1'b0) synced = 1'b1;
    if (!synced) return 2'd0;
    return (hist[hist.size()-1] == 1'b1) ? 2'd2 : 2'd1;
  endfunction

  // driver: one clock of stimulus, called just after a negedge
  task automatic tick(input bit d, input bit rdy, input bit r);
    logic [16:0] acc;
    din     = d;
    m_ready = rdy;
    rst     = r;
    if (!r && rdy && exp_q.size() != 0) begin
      acc = exp_q.pop_front();
      check("accept_data", {15'd0, m_sat, m_gap, m_width}, {15'd0, acc});
    end
    @(posedge clk);
    #1;
    model_update(d, r);
    check("m_valid", {31'd0, m_valid}, {31'd0, exp_q.size() != 0});
    check("record", {15'd0, m_sat, m_gap, m_width}, {15'd0, last_rec});
    check("pulse_cnt", {16'd0, pulse_cnt}, 32'(exp_cnt));
    check("dropped", {31'd0, dropped}, {31'd0, exp_drop});
    check("state", {30'd0, dbg_state}, {30'd0, exp_state()});
    @(negedge clk);
  endtask

  task automatic run(input bit d, input int n, input bit rdy);
    for (int k = 0; k < n; k++) tick(d, rdy, 1'b0);
  endtask

  task automatic do_reset(input bit d);
    tick(d, 1'b1, 1'b1);
    tick(d, 1'b1, 1'b1);
  endtask

  initial begin
    din = 1'b0; m_ready = 1'b0; rst = 1'b1;

    // reset state
    do_reset(1'b0);
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_cnt", {16'd0, pulse_cnt}, 32'd0);

    // basic pulse: gap 10, width 3
    run(1'b0, 10, 1'b1);
    run(1'b1, 3, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    check("tp1_valid", {31'd0, m_valid}, 32'd1);
    check("tp1_width", {24'd0, m_width}, 32'd3);
    check("tp1_gap", {24'd0, m_gap}, 32'd10);
    check("tp1_sat", {31'd0, m_sat}, 32'd0);
    check("tp1_cnt", {16'd0, pulse_cnt}, 32'd1);
    tick(1'b0, 1'b1, 1'b0);
    check("tp1_valid_off", {31'd0, m_valid}, 32'd0);

    // startup high ignored, width-1 pulse reported
    do_reset(1'b1);
    run(1'b1, 5, 1'b1);
    run(1'b0, 2, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("tp2_width", {24'd0, m_width}, 32'd1);
    check("tp2_gap", {24'd0, m_gap}, 32'd2);
    check("tp2_cnt", {16'd0, pulse_cnt}, 32'd1);

    // backpressure and drop
    do_reset(1'b0);
    run(1'b0, 4, 1'b0); run(1'b1, 2, 1'b0);
    run(1'b0, 3, 1'b0); run(1'b1, 5, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("tp3_valid", {31'd0, m_valid}, 32'd1);
    check("tp3_width", {24'd0, m_width}, 32'd2);
    check("tp3_gap", {24'd0, m_gap}, 32'd4);
    check("tp3_drop", {31'd0, dropped}, 32'd1);
    check("tp3_cnt", {16'd0, pulse_cnt}, 32'd2);
    tick(1'b0, 1'b1, 1'b0);
    check("tp3_accepted", {31'd0, m_valid}, 32'd0);

    // width and gap saturation
    do_reset(1'b0);
    tick(1'b0, 1'b1, 1'b0);
    run(1'b1, 300, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    check("tp4_width", {24'd0, m_width}, 32'd255);
    check("tp4_sat", {31'd0, m_sat}, 32'd1);
    run(1'b0, 300, 1'b1);
    run(1'b1, 2, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    check("tp4_gap", {24'd0, m_gap}, 32'd255);

    // reset mid-pulse
    do_reset(1'b0);
    run(1'b0, 3, 1'b1); run(1'b1, 6, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    check("tp5_state", {30'd0, dbg_state}, 32'd0);
    run(1'b1, 3, 1'b1); run(1'b0, 2, 1'b1);
    check("tp5_valid", {31'd0, m_valid}, 32'd0);
    check("tp5_cnt", {16'd0, pulse_cnt}, 32'd0);

    // 1010 x4 after 20 low
    do_reset(1'b0);
    run(1'b0, 20, 1'b1);
    for (int k = 0; k < 4; k++) begin tick(1'b1, 1'b1, 1'b0); tick(1'b0, 1'b1, 1'b0); end
    run(1'b0, 3, 1'b1);
    check("tp6_cnt", {16'd0, pulse_cnt}, 32'd4);

    // random streams with random backpressure and occasional resets
    do_reset(1'b0);
    for (int s = 0; s < 400; s++) begin
      int len;
      bit lvl;
      lvl = s[0];
      len = ($urandom_range(0, 24) == 0) ? int'($urandom_range(250, 262)) : int'($urandom_range(1, 7));
      for (int k = 0; k < len; k++)
        tick(lvl, $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pulse_meter.md
Name: pulse_meter

Overview:
- Downstream consumer of the delay_line serial output: measures each high pulse on a 1-bit stream, plus the low gap preceding it.
- Emits one (width, gap) record per completed pulse over a valid/ready handshake. Keeps a running pulse count and a sticky drop flag.
- Sits after delay_line so a bench or monitor can check pulse shape and timing without per-cycle waveform inspection.

Parameters:
- CNT_W, 8: width of the width and gap counters. Saturate at 2**CNT_W-1.
- TOT_W, 16: width of the running pulse counter. Wraps modulo 2**TOT_W.

Ports:
- clk, in, 1: single clock. All logic on posedge.
- rst, in, 1: reset, synchronous and active-high.
- din, in, 1: serial stream, typically delay_line dout.
- m_valid, out, 1: record available.
- m_ready, in, 1: consumer accepts record when m_valid && m_ready at posedge.
- m_width, out, CNT_W: high-pulse length in cycles.
- m_gap, out, CNT_W: low length before that pulse, in cycles.
- m_sat, out, 1: width or gap saturated in this record.
- pulse_cnt, out, TOT_W: completed pulses since reset, including dropped ones.
- dropped, out, 1: sticky; a completed record was lost because the output was busy.

Behaviour:
- Reset (rst=1 at posedge): all outputs 0, counters 0, din_q=0, state=SYNC. Any in-flight pulse is discarded.
- din is sampled into din_q every cycle. Edges are detected from din vs din_q.
- FSM states:
  - SYNC: wait for din sampled 0. Startup highs and X are ignored, because delay_line has no reset. On the first 0: gap=1, go to LOW.
  - LOW: gap increments per 0-sample, saturating. On a 1-sample: width=1, go to HIGH.
  - HIGH: width increments per 1-sample, saturating. On a 0-sample the pulse is complete: attempt capture, gap=1, go to LOW.
- Capture (slot free, or m_valid && m_ready in the same cycle):
  - m_width/m_gap get the final counts; m_sat = either counter hit max; m_valid=1.
  - Timing: record visible after the posedge that first samples din=0, i.e. 1 cycle of latency.
- Capture when slot busy (m_valid=1 and m_ready=0): new record discarded, held record unchanged, dropped set to 1.
- Simultaneous accept and capture: the new record replaces the old one, m_valid stays 1, no drop.
- Accept with no capture: m_valid cleared next cycle. Data holds its last value.
- pulse_cnt increments on every pulse completion, captured or dropped. Wraps 2**TOT_W-1 -> 0.
- Counters never wrap. They hold at max until cleared by a state transition.
- Outputs are stable while m_valid=1 and m_ready=0.

Optional Feature:
- Macro: PULSE_METER_GLITCH_FILTER_EN.
- Defined: a pulse with width==1 is a glitch. There is no capture and no pulse_cnt increment. Its cycle plus the following low are added to the ongoing gap, saturating.
- Undefined: every pulse is reported, width 1 included.

Decomposition:
- pulse_meter_pkg:
  - state enum: SYNC, LOW, HIGH.
  - localparam for the saturation max.
  - function sat_inc(value, max).
- One sub-module, pm_sat_counter, with ports clk, rst, clr, load1, inc, q, at_max. It is instantiated twice, for width and gap.

Test Plan:
- Reset; din=0 for 10 cycles, 1 for 3, then 0; m_ready=1 -> one record: width=3, gap=10, m_sat=0, pulse_cnt=1; m_valid high 1 cycle.
- din=1 during and after reset release for 5 cycles, then 0 for 2, 1 for 1, 0 -> startup high ignored; record width=1, gap=2, pulse_cnt=1. With the macro defined: no record, pulse_cnt=0.
- m_ready=0; pulses (gap 4, width 2) then (gap 3, width 5) -> m_valid=1 holding width=2, gap=4; dropped=1; pulse_cnt=2. Raise m_ready -> accepted, m_valid=0.
- CNT_W=8; din=1 for 300 cycles, then 0 -> width=255, m_sat=1.
- rst pulsed mid-pulse (width counter at 6) -> next cycle all outputs 0, state SYNC; no record for the aborted pulse.
- Chained delay_line DELAY=4 -> pulse_meter; pattern 1010 x4 after 20 low -> records width=1,1,1,1 and gap=20,1,1,1; each record appears 4 cycles after the undelayed case; pulse_cnt=4.
